// File: rtl/sc_nadder_seq_if.sv
// Bus bundle for sc_nadder_seq: control strobes, stochastic inputs and observed outputs.
// The master drives the stimulus side and the slave (the adder) drives the results.
interface sc_nadder_seq_if #(
   parameter int unsigned INPUT_STREAMS = 4,
   parameter int unsigned LFSR_WIDTH    = 16,
   parameter int unsigned COUNT_WIDTH   = 16
);
   localparam int unsigned SELECT_WIDTH = (INPUT_STREAMS < 2) ? 1 : $clog2(INPUT_STREAMS);

   logic                     en;
   logic [INPUT_STREAMS-1:0] x;
   logic                     seed_load;
   logic [LFSR_WIDTH-1:0]    seed;
   logic                     cnt_clear;
   logic                     out;
   logic                     out_valid;
   logic [SELECT_WIDTH-1:0]  sel_dbg;
   logic [COUNT_WIDTH-1:0]   ones_count;

   modport master (
      output en, x, seed_load, seed, cnt_clear,
      input  out, out_valid, sel_dbg, ones_count
   );

   modport slave (
      input  en, x, seed_load, seed, cnt_clear,
      output out, out_valid, sel_dbg, ones_count
   );
endinterface

// File: rtl/sc_nadder_seq.sv
// Clocked stochastic N-input scaled adder: registers one input bit per enabled cycle,
// chosen by an LFSR or a round-robin counter, and counts the valid ones it produces.
module sc_nadder_seq #(
   parameter int unsigned            INPUT_STREAMS = 4,
   parameter int unsigned            SELECT_MODE   = 0,
   parameter int unsigned            LFSR_WIDTH    = 16,
   parameter logic [LFSR_WIDTH-1:0]  SEED          = LFSR_WIDTH'(16'hACE1),
   parameter int unsigned            COUNT_WIDTH   = 16
) (
   input logic             clk,
   input logic             rst,
   sc_nadder_seq_if.slave  bus
);
   localparam int unsigned SELECT_WIDTH = (INPUT_STREAMS < 2) ? 1 : $clog2(INPUT_STREAMS);

   generate
      if (INPUT_STREAMS < 2) begin : g_err_streams
         $error("sc_nadder_seq: INPUT_STREAMS must be at least 2");
      end
      if (SELECT_MODE > 1) begin : g_err_mode
         $error("sc_nadder_seq: SELECT_MODE must be 0 or 1");
      end
      if (LFSR_WIDTH != 8 && LFSR_WIDTH != 16 && LFSR_WIDTH != 32) begin : g_err_width
         $error("sc_nadder_seq: LFSR_WIDTH must be 8, 16 or 32");
      end
      if (SELECT_MODE == 0 && (INPUT_STREAMS & (INPUT_STREAMS - 1)) != 0) begin : g_err_pow2
         $error("sc_nadder_seq: LFSR select needs a power-of-2 INPUT_STREAMS");
      end
      if (SELECT_MODE == 0 && SELECT_WIDTH > LFSR_WIDTH / 2) begin : g_err_selw
         $error("sc_nadder_seq: SELECT_WIDTH exceeds LFSR_WIDTH/2");
      end
   endgenerate

   logic [SELECT_WIDTH-1:0] sel;

   generate
      if (SELECT_MODE == 1) begin : g_rr
         logic [SELECT_WIDTH-1:0] rr_q, rr_d;

         always_comb begin
            rr_d = rr_q;
            if (bus.seed_load) begin
               rr_d = '0;
            end else if (bus.en) begin
               rr_d = (rr_q == SELECT_WIDTH'(INPUT_STREAMS - 1)) ? '0 : rr_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) rr_q <= '0;
            else     rr_q <= rr_d;
         end

         assign sel = rr_q;
      end else begin : g_lfsr
         // Tap masks for the supported lengths: 8:8,6,5,4  16:16,14,13,11  32:32,22,2,1
         localparam logic [31:0] TAPS32 = (LFSR_WIDTH == 8)  ? 32'h0000_00B8 :
                                          (LFSR_WIDTH == 16) ? 32'h0000_B400 :
                                                               32'h8020_0003;
         localparam logic [LFSR_WIDTH-1:0] TAPS      = TAPS32[LFSR_WIDTH-1:0];
         localparam logic [LFSR_WIDTH-1:0] RESET_VAL = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;

         logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
         logic                  fb;

         assign fb = ^(lfsr_q & TAPS);

         always_comb begin
            lfsr_d = lfsr_q;
            if (bus.seed_load) begin
               lfsr_d = (bus.seed == '0) ? LFSR_WIDTH'(1) : bus.seed;
            end else if (bus.en) begin
               lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], fb};
            end
         end

         always_ff @(posedge clk) begin
            if (rst) lfsr_q <= RESET_VAL;
            else     lfsr_q <= lfsr_d;
         end

         assign sel = lfsr_q[SELECT_WIDTH-1:0];
      end
   endgenerate

   logic                   out_q, out_d;
   logic                   valid_q, valid_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      out_d   = out_q;
      valid_d = 1'b0;
      if (!bus.seed_load && bus.en) begin
         out_d   = bus.x[sel];
         valid_d = 1'b1;
      end
   end

   // Counts the bit registered on the previous edge; clear beats increment.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clear) begin
         cnt_d = '0;
      end else if (valid_q && out_q && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.out        = out_q;
   assign bus.out_valid  = valid_q;
   assign bus.sel_dbg    = sel;
   assign bus.ones_count = cnt_q;
endmodule

// File: tb/tb_sc_nadder_seq.sv
// Directed bench for sc_nadder_seq: three configurations driven in sequence, with expected
// output bits queued at drive time and popped when the DUT reports a valid bit.
module tb_sc_nadder_seq;
   logic clk;
   logic rst;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;
   logic        exp_q[$];

   sc_nadder_seq_if #(.INPUT_STREAMS(3), .LFSR_WIDTH(16), .COUNT_WIDTH(16)) b3 ();
   sc_nadder_seq_if #(.INPUT_STREAMS(4), .LFSR_WIDTH(16), .COUNT_WIDTH(16)) b4l ();
   sc_nadder_seq_if #(.INPUT_STREAMS(4), .LFSR_WIDTH(16), .COUNT_WIDTH(4))  b4r ();

   sc_nadder_seq #(.INPUT_STREAMS(3), .SELECT_MODE(1), .LFSR_WIDTH(16), .COUNT_WIDTH(16))
      u_rr3 (.clk(clk), .rst(rst), .bus(b3));
   sc_nadder_seq #(.INPUT_STREAMS(4), .SELECT_MODE(0), .LFSR_WIDTH(16), .COUNT_WIDTH(16))
      u_lf4 (.clk(clk), .rst(rst), .bus(b4l));
   sc_nadder_seq #(.INPUT_STREAMS(4), .SELECT_MODE(1), .LFSR_WIDTH(16), .COUNT_WIDTH(4))
      u_rr4 (.clk(clk), .rst(rst), .bus(b4r));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic obs);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_mis++;
         $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
      end else begin
         chk(tag, 32'(obs), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      logic [2:0] x3;
      logic [3:0] x4;
      logic       held;
      int         sel_lf[4]  = '{1, 2, 0, 0};
      int         en_pat[5]  = '{1, 0, 0, 1, 1};
      int         sel_pat[5] = '{0, 1, 1, 1, 2};
      logic [15:0] cnt;

      rst = 1'b1;
      b3.en = 0;  b3.x = '0;  b3.seed_load = 0;  b3.seed = '0;  b3.cnt_clear = 0;
      b4l.en = 0; b4l.x = '0; b4l.seed_load = 0; b4l.seed = '0; b4l.cnt_clear = 0;
      b4r.en = 0; b4r.x = '0; b4r.seed_load = 0; b4r.seed = '0; b4r.cnt_clear = 0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_out",   32'(b3.out), 0);
      chk("rst_valid", 32'(b3.out_valid), 0);
      chk("rst_cnt",   32'(b3.ones_count), 0);
      chk("rst_sel_rr",   32'(b3.sel_dbg), 0);
      chk("rst_sel_lfsr", 32'(b4l.sel_dbg), 32'h1);

      // Round-robin over 3 streams, x=101
      x3 = 3'b101;
      b3.x = x3;
      b3.en = 1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(x3[i % 3]);
         tick();
         chk("t1_valid", 32'(b3.out_valid), 1);
         sb_check("t1_out", b3.out);
      end
      b3.en = 0;
      tick();
      chk("t1_valid_off", 32'(b3.out_valid), 0);
      chk("t1_ones", 32'(b3.ones_count), 4);

      // LFSR select after seeding with 1
      b4l.seed = 16'h0001;
      b4l.seed_load = 1;
      tick();
      b4l.seed_load = 0;
      chk("t2_seed_valid", 32'(b4l.out_valid), 0);
      x4 = 4'b0010;
      b4l.x = x4;
      b4l.en = 1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_sel", 32'(b4l.sel_dbg), 32'(sel_lf[i]));
         exp_q.push_back(x4[sel_lf[i]]);
         tick();
         sb_check("t2_out", b4l.out);
      end
      b4l.en = 0;
      tick();

      // Enable gaps on round-robin N=4
      x4 = 4'b0100;
      b4r.x = x4;
      held = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b4r.en = en_pat[i][0];
         chk("t3_sel", 32'(b4r.sel_dbg), 32'(sel_pat[i]));
         if (en_pat[i] != 0) begin
            held = x4[sel_pat[i]];
            exp_q.push_back(held);
         end
         tick();
         chk("t3_valid", 32'(b4r.out_valid), 32'(en_pat[i]));
         if (en_pat[i] != 0) sb_check("t3_out", b4r.out);
         else                chk("t3_hold", 32'(b4r.out), 32'(held));
      end
      b4r.en = 0;
      b4r.x = '0;
      tick();
      tick();
      chk("t3_hold_after", 32'(b4r.out), 1);

      // Reset in the middle of a burst
      b4r.x = 4'b1111;
      b4r.en = 1;
      for (int i = 0; i < 5; i++) tick();
      chk("t4_cnt_before", 32'(b4r.ones_count), 5);
      rst = 1;
      tick();
      chk("t4_out",   32'(b4r.out), 0);
      chk("t4_valid", 32'(b4r.out_valid), 0);
      chk("t4_cnt",   32'(b4r.ones_count), 0);
      chk("t4_sel",   32'(b4r.sel_dbg), 0);
      chk("t4_sel_lfsr", 32'(b4l.sel_dbg), 32'h1);
      rst = 0;
      b4r.en = 0;

      // Zero seed, seed_load vs en, rst vs seed_load
      b4l.seed = '0;
      b4l.seed_load = 1;
      tick();
      b4l.seed_load = 0;
      chk("t5_zero_seed", 32'(b4l.sel_dbg), 1);
      b4l.x = '0;
      b4l.en = 1;
      tick();
      b4l.en = 0;
      chk("t5_zero_step", 32'(b4l.sel_dbg), 2);
      b4l.x = 4'b1111;
      b4l.en = 1;
      b4l.seed = 16'h0003;
      b4l.seed_load = 1;
      tick();
      chk("t5_load_en_valid", 32'(b4l.out_valid), 0);
      chk("t5_load_en_out",   32'(b4l.out), 0);
      chk("t5_load_en_sel",   32'(b4l.sel_dbg), 3);
      b4l.en = 0;
      b4l.seed = 16'h0002;
      rst = 1;
      tick();
      rst = 0;
      b4l.seed_load = 0;
      chk("t5_rst_load_sel",   32'(b4l.sel_dbg), 1);
      chk("t5_rst_load_valid", 32'(b4l.out_valid), 0);

      // cnt_clear beats a pending increment
      b4r.x = 4'b1111;
      b4r.en = 1;
      tick();
      tick();
      chk("t5_cnt_pre", 32'(b4r.ones_count), 1);
      b4r.cnt_clear = 1;
      tick();
      chk("t5_clear", 32'(b4r.ones_count), 0);
      b4r.en = 0;
      tick();
      b4r.cnt_clear = 0;

      // Saturation of a 4-bit counter
      b4r.en = 1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 15) chk("t6_cnt14", 32'(b4r.ones_count), 14);
         if (i == 16) chk("t6_cnt15", 32'(b4r.ones_count), 15);
      end
      b4r.en = 0;
      tick();
      tick();
      chk("t6_sat_hold", 32'(b4r.ones_count), 15);

      // LFSR statistics: half the inputs are ones
      b4l.cnt_clear = 1;
      tick();
      b4l.cnt_clear = 0;
      b4l.x = 4'b0011;
      b4l.en = 1;
      for (int i = 0; i < 4096; i++) tick();
      b4l.en = 0;
      tick();
      cnt = b4l.ones_count;
      chk("t6_stats_in_range", 32'(cnt >= 16'd1920 && cnt <= 16'd2176), 1);
      chk("t6_sb_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/sc_nadder_seq.md
Name: sc_nadder_seq

Overview:
Clocked, parametrised successor to the combinational stochastic N-input scaled adder. Selects one of INPUT_STREAMS stochastic bits per enabled cycle and registers the choice, producing a stream of value sum(x_i)/INPUT_STREAMS. The select sequence is generated internally, either by an LFSR (random select) or by a round-robin counter (deterministic, exact scaling). Sits between stochastic number generators and downstream SC arithmetic or stream-to-binary counters. An on-block ones counter supports in-situ checking.

Parameters:
INPUT_STREAMS, 4, number of input streams; must be >=2; any value in round-robin mode; power of 2 in LFSR mode.
SELECT_MODE, 0, 0 = LFSR select, 1 = round-robin select.
LFSR_WIDTH, 16, LFSR length; legal values are 8, 16 and 32; other values are an elaboration error.
SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 1.
COUNT_WIDTH, 16, width of the ones counter.
SELECT_WIDTH, clog2(INPUT_STREAMS), derived local parameter; must be <= LFSR_WIDTH/2 in LFSR mode.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
en  input  1  sample strobe; one output bit per enabled cycle
x  input  INPUT_STREAMS  input stochastic bits, one per stream
seed_load  input  1  load LFSR from seed and clear the round-robin counter
seed  input  LFSR_WIDTH  seed value, used only when seed_load=1
cnt_clear  input  1  clears ones_count
out  output  1  registered selected bit
out_valid  output  1  high for one cycle per accepted en
sel_dbg  output  SELECT_WIDTH  select value in use for the current cycle
ones_count  output  COUNT_WIDTH  number of valid output ones since reset or clear

Behaviour:
- Reset (rst=1 at edge): out=0, out_valid=0, ones_count=0, rr counter=0, LFSR=SEED (1 if SEED==0). rst overrides every other input.
- Per-edge priority: rst > seed_load > en.
- seed_load=1:
  - LFSR <= seed, or 1 if seed==0; rr counter <= 0.
  - out holds its value; out_valid <= 0 even when en=1.
  - ones_count is not changed by seed_load.
- en=1 (no rst, no seed_load):
  - out <= x[sel]; out_valid <= 1; select state advances one step.
  - Latency is 1 cycle: x sampled at edge k appears on out after edge k.
- en=0: out holds, out_valid <= 0, select state holds. Idle cycles must not advance the select sequence.
- Select, LFSR mode:
  - sel = LFSR[SELECT_WIDTH-1:0], taken combinationally from the current LFSR.
  - Fibonacci LFSR, left shift: next = {L[W-2:0], fb}.
  - fb is the XOR of the tap bits. Taps (1-based): W=8 -> 8,6,5,4; W=16 -> 16,14,13,11; W=32 -> 32,22,2,1.
  - The LFSR never holds 0.
- Select, round-robin mode:
  - sel = counter, which steps 0,1,...,INPUT_STREAMS-1 and wraps to 0.
  - Over every INPUT_STREAMS consecutive enabled cycles, each input is selected exactly once.
- sel_dbg = sel as used at the next enabled edge.
- ones_count:
  - Increments when out_valid=1 and out=1, i.e. it counts the bit registered on the previous edge.
  - Saturates at all-ones; no wrap.
  - cnt_clear=1 sets it to 0 and takes precedence over an increment in the same cycle.
  - rst also sets it to 0.
- Illegal parameter combinations (INPUT_STREAMS<2, non-power-of-2 in LFSR mode, illegal LFSR_WIDTH, SELECT_WIDTH too large) must stop elaboration.

Test Plan:
1. Round-robin: SELECT_MODE=1, INPUT_STREAMS=3, x=3'b101 held, en=1 for 6 cycles -> out = 1,0,1,1,0,1; out_valid high on each of those 6 cycles; ones_count reaches 4.
2. LFSR sequence: SELECT_MODE=0, N=4, W=16, seed_load with seed=16'h0001, then x=4'b0010 and en=1 for 4 cycles -> sel = 1,2,0,0; out = 1,0,0,0.
3. Enable gaps: round-robin N=4, en pattern 1,0,0,1,1 with x=4'b0100 -> sel steps 0,1,2 only on enabled cycles; out_valid = 1,0,0,1,1; out holds during gaps.
4. Reset mid-operation: assert rst after 5 enabled cycles, with en still high -> next cycle out=0, out_valid=0, ones_count=0, sel_dbg=0 (round-robin) or SEED[1:0] (LFSR).
5. Zero seed, edge priority and clear: seed_load with seed=0 -> LFSR=1. seed_load and en in the same cycle -> out_valid=0. rst and seed_load together -> reset state. cnt_clear and an increment together -> ones_count=0.
6. Saturation and statistics:
   - COUNT_WIDTH=4, x all ones, en for 20 cycles -> ones_count=15 and holds.
   - LFSR mode, N=4, x=4'b0011, 4096 enabled cycles -> ones_count within 2048±128.
